// File: rtl/hist_cdf_builder.sv
// Builds a 256-bin histogram of one frame, scans it into a CDF table, and serves cdf/cdf_min lookups; optional HIST_STATS_EN adds peak_bin/peak_count.
// Latency: start to cdf_valid = 1 + NUM_PIXELS accepted beats + 2^PIX_W + 1 cycles; lookups are 1 clock.
// Backpressure: pxl_ready is high only while accumulating and drops the cycle after the last pixel is accepted.
module hist_cdf_builder #(
    parameter int NUM_PIXELS = 76800,
    parameter int PIX_W      = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] pxl_in,
    input  logic             pxl_valid,
    output logic             pxl_ready,
    input  logic [PIX_W-1:0] lut_addr,
    output logic [CNT_W-1:0] cdf,
    output logic [CNT_W-1:0] cdf_min,
    output logic             cdf_valid,
    output logic             busy
`ifdef HIST_STATS_EN
    ,
    output logic [PIX_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count
`endif
);

    localparam int NBINS = 1 << PIX_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PIX_W-1:0] IDX_ONE  = {{(PIX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SCAN,
        S_READY
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] bin_q     [NBINS];
    logic [CNT_W-1:0] cdf_tab_q [NBINS];
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] acc_q;
    logic [PIX_W-1:0] idx_q;
    logic [CNT_W-1:0] cdf_min_q;
    logic             found_q;
    logic [CNT_W-1:0] cdf_q;
    logic             cdf_valid_q;
    logic             pxl_ready_q;
    logic             busy_q;
`ifdef HIST_STATS_EN
    logic [PIX_W-1:0] peak_bin_q;
    logic [CNT_W-1:0] peak_count_q;
`endif

    logic             accept;
    logic             last_pix;
    logic             last_idx;
    logic [CNT_W-1:0] scan_sum_d;

    always_comb begin
        accept     = 1'b0;
        last_pix   = 1'b0;
        last_idx   = 1'b0;
        scan_sum_d = '0;
        accept     = (state_q == S_ACCUM) && pxl_valid && pxl_ready_q;
        last_pix   = (pix_cnt_q == LAST_PIX);
        last_idx   = (idx_q == {PIX_W{1'b1}});
        scan_sum_d = acc_q + bin_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NBINS; i++) begin
                bin_q[i]     <= '0;
                cdf_tab_q[i] <= '0;
            end
            pix_cnt_q   <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            cdf_min_q   <= '0;
            found_q     <= 1'b0;
            cdf_q       <= '0;
            cdf_valid_q <= 1'b0;
            pxl_ready_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef HIST_STATS_EN
            peak_bin_q   <= '0;
            peak_count_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    for (int i = 0; i < NBINS; i++) begin
                        bin_q[i]     <= '0;
                        cdf_tab_q[i] <= '0;
                    end
                    pix_cnt_q   <= '0;
                    acc_q       <= '0;
                    idx_q       <= '0;
                    cdf_min_q   <= '0;
                    found_q     <= 1'b0;
                    cdf_valid_q <= 1'b0;
`ifdef HIST_STATS_EN
                    peak_bin_q   <= '0;
                    peak_count_q <= '0;
`endif
                    pxl_ready_q <= 1'b1;
                    state_q     <= S_ACCUM;
                end
                S_ACCUM: begin
                    // Each accept is a full read-modify-write of one bin, so repeats of a value never collide.
                    if (accept) begin
                        bin_q[pxl_in] <= bin_q[pxl_in] + CNT_ONE;
                        pix_cnt_q     <= pix_cnt_q + CNT_ONE;
                        if (last_pix) begin
                            pxl_ready_q <= 1'b0;
                            state_q     <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    acc_q            <= scan_sum_d;
                    cdf_tab_q[idx_q] <= scan_sum_d;
                    if (!found_q && (scan_sum_d != '0)) begin
                        cdf_min_q <= scan_sum_d;
                        found_q   <= 1'b1;
                    end
`ifdef HIST_STATS_EN
                    // Strict compare keeps the lower index on ties.
                    if (bin_q[idx_q] > peak_count_q) begin
                        peak_bin_q   <= idx_q;
                        peak_count_q <= bin_q[idx_q];
                    end
`endif
                    idx_q <= idx_q + IDX_ONE;
                    if (last_idx) begin
                        state_q <= S_READY;
                        busy_q  <= 1'b0;
                    end
                end
                S_READY: begin
                    if (start) begin
                        state_q     <= S_CLEAR;
                        busy_q      <= 1'b1;
                        cdf_valid_q <= 1'b0;
                        cdf_q       <= '0;
                    end else begin
                        // cdf_valid rises with the first registered lookup so both are usable together.
                        cdf_q       <= cdf_tab_q[lut_addr];
                        cdf_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pxl_ready = pxl_ready_q;
    assign cdf       = cdf_q;
    assign cdf_min   = cdf_min_q;
    assign cdf_valid = cdf_valid_q;
    assign busy      = busy_q;
`ifdef HIST_STATS_EN
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;
`endif

endmodule

// File: tb/tb_hist_cdf_builder.sv
// Randomized frames against a histogram/prefix-sum reference model; frame size is reduced to keep runs short.
module tb_hist_cdf_builder;

    localparam int N     = 1024;
    localparam int PIX_W = 8;
    localparam int CNT_W = 32;
    localparam int NB    = 256;

    localparam int M_RAND   = 0;
    localparam int M_CONST  = 1;
    localparam int M_SPREAD = 2;
    localparam int M_HEAVY7 = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PIX_W-1:0] pxl_in;
    logic             pxl_valid;
    logic             pxl_ready;
    logic [PIX_W-1:0] lut_addr;
    logic [CNT_W-1:0] cdf;
    logic [CNT_W-1:0] cdf_min;
    logic             cdf_valid;
    logic             busy;
`ifdef HIST_STATS_EN
    logic [PIX_W-1:0] peak_bin;
    logic [CNT_W-1:0] peak_count;
`endif

    hist_cdf_builder #(.NUM_PIXELS(N), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pxl_in    (pxl_in),
        .pxl_valid (pxl_valid),
        .pxl_ready (pxl_ready),
        .lut_addr  (lut_addr),
        .cdf       (cdf),
        .cdf_min   (cdf_min),
        .cdf_valid (cdf_valid),
        .busy      (busy)
`ifdef HIST_STATS_EN
        ,
        .peak_bin  (peak_bin),
        .peak_count(peak_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int unsigned pix   [N];
    int unsigned hist  [NB];
    int unsigned cdf_m [NB];
    int unsigned cdf_min_m;
    int unsigned peak_bin_m;
    int unsigned peak_cnt_m;

    task automatic check(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic gen_frame(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                M_CONST:  pix[i] = 128;
                M_SPREAD: pix[i] = i % NB;
                M_HEAVY7: pix[i] = (i < 600) ? 7 : $urandom_range(8, 255);
                default:  pix[i] = $urandom_range(0, 255);
            endcase
        end
        if (mode == M_HEAVY7 || mode == M_SPREAD) begin
            for (int i = 0; i < N; i++) begin
                int j;
                int unsigned t;
                j = $urandom_range(0, N - 1);
                t = pix[i]; pix[i] = pix[j]; pix[j] = t;
            end
        end
        for (int k = 0; k < NB; k++) hist[k] = 0;
        for (int i = 0; i < N; i++) hist[pix[i]]++;
        cdf_min_m  = 0;
        peak_bin_m = 0;
        peak_cnt_m = 0;
        for (int k = 0; k < NB; k++) begin
            cdf_m[k] = (k == 0) ? hist[0] : cdf_m[k-1] + hist[k];
            if (cdf_min_m == 0) cdf_min_m = cdf_m[k];
            if (hist[k] > peak_cnt_m) begin
                peak_cnt_m = hist[k];
                peak_bin_m = k;
            end
        end
    endtask

    task automatic run_frame(input int mode, input bit scan_start, input bit reset_mid);
        int sent;
        int cyc;
        int k;
        int leak;
        int prev_addr;
        gen_frame(mode);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clear_busy", {31'd0, busy}, 1);
        check("clear_ready", {31'd0, pxl_ready}, 0);
        check("clear_valid", {31'd0, cdf_valid}, 0);
        check("clear_cdf", cdf, 0);

        sent = 0;
        cyc  = 0;
        while (sent < N && cyc < 8 * N) begin
            pxl_valid = ($urandom_range(0, 3) != 0);
            pxl_in    = pix[sent][PIX_W-1:0];
            if (pxl_valid && pxl_ready) sent++;
            if (reset_mid && sent == 500) begin
                #2 rst = 1'b1;
                #1;
                check("rst_cdf", cdf, 0);
                check("rst_cdf_min", cdf_min, 0);
                check("rst_valid", {31'd0, cdf_valid}, 0);
                check("rst_ready", {31'd0, pxl_ready}, 0);
                check("rst_busy", {31'd0, busy}, 0);
                @(negedge clk);
                rst       = 1'b0;
                pxl_valid = 1'b0;
                repeat (3) @(negedge clk);
                check("idle_busy", {31'd0, busy}, 0);
                check("idle_ready", {31'd0, pxl_ready}, 0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        check("accepted", sent, N);

        k    = 0;
        leak = 0;
        while (!cdf_valid && k < 400) begin
            pxl_valid = (k < 10);
            pxl_in    = PIX_W'($urandom_range(0, 255));
            start     = scan_start && (k == 100);
            if (pxl_valid && pxl_ready) leak++;
            if (k == 5) check("scan_cdf_zero", cdf, 0);
            @(negedge clk);
            k++;
        end
        pxl_valid = 1'b0;
        start     = 1'b0;
        check("extra_accepts", leak, 0);
        check("valid_latency", k, 257);
        check("cdf_min", cdf_min, cdf_min_m);
        if (mode == M_CONST) check("cdf_min_uniform", cdf_min, N);
`ifdef HIST_STATS_EN
        check("peak_bin", {24'd0, peak_bin}, peak_bin_m);
        check("peak_count", peak_count, peak_cnt_m);
        if (mode == M_HEAVY7) begin
            check("peak_bin7", {24'd0, peak_bin}, 7);
            check("peak_count7", peak_count, 600);
        end
`endif

        prev_addr = -1;
        for (int a = 0; a < NB; a++) begin
            int addr;
            addr     = (mode == M_RAND) ? $urandom_range(0, 255) : a;
            lut_addr = PIX_W'(addr);
            #1;
            if (prev_addr >= 0) check("lut_hold", cdf, cdf_m[prev_addr]);
            @(negedge clk);
            check($sformatf("cdf[%0d]", addr), cdf, cdf_m[addr]);
            prev_addr = addr;
        end
        lut_addr = 8'd255;
        @(negedge clk);
        check("cdf_last", cdf, N);
        check("ready_valid", {31'd0, cdf_valid}, 1);
        check("ready_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pxl_in    = '0;
        pxl_valid = 1'b0;
        lut_addr  = '0;
        repeat (3) @(negedge clk);
        check("por_cdf", cdf, 0);
        check("por_cdf_min", cdf_min, 0);
        check("por_valid", {31'd0, cdf_valid}, 0);
        check("por_ready", {31'd0, pxl_ready}, 0);
        check("por_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_start_busy", {31'd0, busy}, 0);

        run_frame(M_RAND, 1'b0, 1'b1);
        run_frame(M_RAND, 1'b0, 1'b0);
        run_frame(M_CONST, 1'b1, 1'b0);
        run_frame(M_SPREAD, 1'b0, 1'b0);
        run_frame(M_HEAVY7, 1'b1, 1'b0);
        run_frame(M_RAND, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hist_cdf_builder.md
Name: hist_cdf_builder

Overview:
- Producer side of the histogram-equalisation path.
- Takes one greyscale frame of decoded 8-bit pixels and builds a 256-bin histogram.
- Converts the histogram into a cumulative distribution (CDF) and finds cdf_min.
- Then serves per-pixel CDF lookups (cdf, cdf_min) to the equalisation mapper.
- Sits between the JPEG decoder output stream and the equaliser.

Parameters:
- NUM_PIXELS, 76800, pixels per frame (320x240); the frame ends when this many pixels are accepted.
- PIX_W, 8, pixel width; bin count is 2^PIX_W.
- CNT_W, 32, width of bin counters, cdf and cdf_min.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a new frame; honoured only in IDLE or READY.
- pxl_in  in  PIX_W  incoming pixel value.
- pxl_valid  in  1  pxl_in is valid this cycle.
- pxl_ready  out  1  block accepts a pixel this cycle (high only in ACCUM).
- lut_addr  in  PIX_W  pixel value to look up.
- cdf  out  CNT_W  registered CDF for lut_addr.
- cdf_min  out  CNT_W  first non-zero CDF value of the frame.
- cdf_valid  out  1  tables are complete; cdf and cdf_min are usable.
- busy  out  1  high in CLEAR, ACCUM and SCAN.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all bins, CDF entries and the pixel counter go to 0.
  - All outputs are 0: cdf=0, cdf_min=0, cdf_valid=0, pxl_ready=0, busy=0.
  - Reset asserted mid-frame discards all partial data. No output glitches beyond the async clear.
- States:
  - IDLE: waits for start, then goes to CLEAR.
  - CLEAR: one cycle. All 2^PIX_W bins, the CDF table, the pixel counter, cdf_min and the found flag are zeroed; cdf_valid goes to 0. Next state is ACCUM.
  - ACCUM:
    - pxl_ready=1. On pxl_valid&&pxl_ready, bin[pxl_in] increments by 1 and the pixel counter increments.
    - Back-to-back identical values must each be counted; a single-cycle register-array read-modify-write has no hazard.
    - When the accepted count reaches NUM_PIXELS, go to SCAN. pxl_ready drops the cycle after the last accept.
  - SCAN:
    - One bin per cycle, index i = 0..2^PIX_W-1.
    - acc <= acc + bin[i]; cdf_tab[i] <= acc + bin[i].
    - The first i with a non-zero sum latches cdf_min (once per frame).
    - After i = 2^PIX_W-1, go to READY. SCAN takes exactly 2^PIX_W cycles.
  - READY:
    - cdf_valid=1.
    - cdf <= cdf_tab[lut_addr] every cycle; lookup latency is 1 clock.
    - A start pulse goes to CLEAR. cdf_valid falls in the CLEAR cycle.
- start is ignored in CLEAR, ACCUM and SCAN.
- cdf is 0 whenever the state is not READY.
- Arithmetic:
  - Unsigned throughout.
  - The final cdf_tab[255] equals NUM_PIXELS.
  - Bin counters never overflow because NUM_PIXELS < 2^CNT_W.
- Frame latency: start to cdf_valid = 1 (CLEAR) + NUM_PIXELS accepted beats + 2^PIX_W (SCAN) + 1 cycles.
- Uniform-value frame: cdf_min = NUM_PIXELS. The equaliser treats a zero denominator separately; this block does not guard it.

Optional Feature:
- HIST_STATS_EN: when defined, adds two outputs:
  - peak_bin (PIX_W): index of the largest histogram bin.
  - peak_count (CNT_W): count in that bin.
- Both are tracked during SCAN, with ties going to the lower index, and are valid together with cdf_valid. Reset and CLEAR set both to 0.
- When undefined, both ports and all related logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset mid-ACCUM (after 1000 pixels) -> all outputs 0, state IDLE; a following start plus a full frame gives correct tables with no residue.
- Frame of 76800 pixels all value 128 -> cdf_min=76800; lookup 127 gives cdf=0; lookup 128 and 255 give 76800; cdf_valid rises exactly 257 cycles after the last accept.
- Frame of 300 pixels each of values 0..255 (76800 total) -> cdf[k]=300*(k+1), cdf_min=300; lookup latency is exactly 1 cycle.
- pxl_valid toggled randomly, plus 10 extra pixels offered after the 76800th -> extras not accepted (pxl_ready=0); cdf[255]=76800.
- start pulsed during SCAN -> ignored; a start in READY -> CLEAR, cdf_valid 0 the next cycle, and second-frame results are independent of the first.
- HIST_STATS_EN build, frame with 40000 pixels of value 7 and the rest spread over other values -> peak_bin=7, peak_count=40000.
